// File: rtl/char_motion_ctrl.sv
// rtl/char_motion_ctrl.sv - per-character X motion: walk, lunge, opponent blocking, knockback
// Knockback logic is present only when CHAR_MOTION_KNOCKBACK_EN is defined.
module char_motion_ctrl #(
    parameter logic [9:0] INIT_X       = 10'd40,
    parameter logic [9:0] INIT_Y       = 10'd200,
    parameter logic [9:0] MIN_X        = 10'd40,
    parameter logic [9:0] MAX_X        = 10'd600,
    parameter logic [9:0] CHAR_WIDTH   = 10'd128,
    parameter logic [9:0] WALK_STEP    = 10'd2,
    parameter logic [9:0] LUNGE_STEP   = 10'd4,
    parameter logic [9:0] KNOCK_STEP   = 10'd6,
    parameter logic [7:0] KNOCK_FRAMES = 8'd8,
    parameter logic       FACE_RIGHT   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] state,
    input  logic [9:0] opp_x,
    input  logic       knock_req,
    output logic [9:0] char_x,
    output logic [9:0] char_y,
    output logic       knock_busy,
    output logic       at_left,
    output logic       at_right
);
    localparam logic [3:0]  S_LEFT       = 4'd1;
    localparam logic [3:0]  S_RIGHT      = 4'd2;
    localparam logic [3:0]  S_DIR_ACTIVE = 4'd7;
    localparam logic [9:0]  RIGHT_X      = MAX_X - CHAR_WIDTH;
    localparam logic [10:0] ARENA_L      = {1'b0, MIN_X};
    localparam logic [10:0] ARENA_R      = {1'b0, RIGHT_X};
    localparam logic [10:0] CW           = {1'b0, CHAR_WIDTH};
    localparam logic [10:0] WS           = {1'b0, WALK_STEP};
    localparam logic [10:0] LS           = {1'b0, LUNGE_STEP};
    localparam logic [10:0] KS           = {1'b0, KNOCK_STEP};

    logic [10:0] x11;
    logic [10:0] opp11;
    logic [10:0] lim_l;
    logic [10:0] lim_r;
    logic [10:0] nx;
    logic        knocking;
    logic        unused_ok;

    // A position already past a limit is left alone rather than snapped back.
    function automatic logic [10:0] step_dn(input logic [10:0] x, input logic [10:0] s,
                                            input logic [10:0] lo);
        if (x < lo)
            return x;
        else if (x < lo + s)
            return lo;
        else
            return x - s;
    endfunction

    function automatic logic [10:0] step_up(input logic [10:0] x, input logic [10:0] s,
                                            input logic [10:0] hi);
        if (x > hi)
            return x;
        else if (x + s > hi)
            return hi;
        else
            return x + s;
    endfunction

    assign x11   = {1'b0, char_x};
    assign opp11 = {1'b0, opp_x};

    always_comb begin
        lim_l = ARENA_L;
        lim_r = ARENA_R;
        if (FACE_RIGHT) begin
            if (opp11 < ARENA_L + CW)
                lim_r = ARENA_L;
            else if (opp11 - CW < ARENA_R)
                lim_r = opp11 - CW;
        end else begin
            if (opp11 + CW > ARENA_L)
                lim_l = opp11 + CW;
            if (lim_l > lim_r)
                lim_l = lim_r;
        end
    end

    always_comb begin
        nx = x11;
        if (knocking) begin
            // knockback ignores the opponent body, only the arena walls stop it
            nx = FACE_RIGHT ? step_dn(x11, KS, ARENA_L) : step_up(x11, KS, ARENA_R);
        end else begin
            case (state)
                S_LEFT:       nx = step_dn(x11, WS, lim_l);
                S_RIGHT:      nx = step_up(x11, WS, lim_r);
                S_DIR_ACTIVE: nx = FACE_RIGHT ? step_up(x11, LS, lim_r) : step_dn(x11, LS, lim_l);
                default:      nx = x11;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            char_x <= INIT_X;
        else if (frame_tick)
            char_x <= nx[9:0];
    end

`ifdef CHAR_MOTION_KNOCKBACK_EN
    logic [7:0] knock_cnt;

    // A hit landing on a tick consumes that tick as the first knockback step.
    always_ff @(posedge clk) begin
        if (rst)
            knock_cnt <= 8'd0;
        else if (knock_req)
            knock_cnt <= frame_tick ? KNOCK_FRAMES - 8'd1 : KNOCK_FRAMES;
        else if (frame_tick && knock_cnt != 8'd0)
            knock_cnt <= knock_cnt - 8'd1;
    end

    assign knocking   = (knock_cnt != 8'd0) || knock_req;
    assign knock_busy = (knock_cnt != 8'd0);
    assign unused_ok  = nx[10];
`else
    assign knocking   = 1'b0;
    assign knock_busy = 1'b0;
    assign unused_ok  = ^{nx[10], knock_req, KNOCK_FRAMES};
`endif

    assign char_y   = INIT_Y;
    assign at_left  = (char_x == MIN_X);
    assign at_right = (char_x == RIGHT_X);
endmodule

// File: tb/tb_char_motion_ctrl.sv
// tb/tb_char_motion_ctrl.sv - self-checking bench: vector table, corner sequences, random vs reference model
module tb_char_motion_ctrl;
    localparam int KF = 8;
`ifdef CHAR_MOTION_KNOCKBACK_EN
    localparam bit KEN = 1'b1;
    localparam int EXP_K1 = 252;
    localparam int EXP_K1B = 256;
    localparam int EXP_K2 = 234;
`else
    localparam bit KEN = 1'b0;
    localparam int EXP_K1 = 316;
    localparam int EXP_K1B = 320;
    localparam int EXP_K2 = 322;
`endif
    localparam int ARENA_LO = 40;
    localparam int ARENA_HI = 600 - 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] st [2];
    logic [9:0] opp [2];
    logic       kq [2];
    logic [9:0] cx [2];
    logic [9:0] cy [2];
    logic       busy [2];
    logic       al [2];
    logic       ar [2];

    int mx [2];
    int mc [2];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    char_motion_ctrl #(.FACE_RIGHT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .state(st[0]), .opp_x(opp[0]),
        .knock_req(kq[0]), .char_x(cx[0]), .char_y(cy[0]), .knock_busy(busy[0]),
        .at_left(al[0]), .at_right(ar[0]));

    char_motion_ctrl #(.FACE_RIGHT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .state(st[1]), .opp_x(opp[1]),
        .knock_req(kq[1]), .char_x(cx[1]), .char_y(cy[1]), .knock_busy(busy[1]),
        .at_left(al[1]), .at_right(ar[1]));

    // Move x by a signed displacement d, stopping at [lo, hi]; a position already
    // past the limit being approached stays put.
    function automatic int mv(int x, int d, int lo, int hi);
        if (d < 0) begin
            if (x < lo) return x;
            return (x + d < lo) ? lo : x + d;
        end
        if (x > hi) return x;
        return (x + d > hi) ? hi : x + d;
    endfunction

    function automatic int model_pos(int x, int s, int o, bit face, bit knocking);
        int lo, hi, dir;
        if (face) begin
            lo = ARENA_LO;
            hi = (o < ARENA_LO + 128) ? ARENA_LO : ((o - 128 < ARENA_HI) ? o - 128 : ARENA_HI);
        end else begin
            hi = ARENA_HI;
            lo = (o + 128 > ARENA_LO) ? o + 128 : ARENA_LO;
            if (lo > hi) lo = hi;
        end
        dir = face ? 1 : -1;  // +1 means the opponent is to the right
        if (knocking) return mv(x, -6 * dir, ARENA_LO, ARENA_HI);
        case (s)
            1: return mv(x, -2, lo, hi);
            2: return mv(x, 2, lo, hi);
            7: return mv(x, 4 * dir, lo, hi);
            default: return x;
        endcase
    endfunction

    task automatic chk(input string name, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst=%0d actual=%0d expected=%0d t=%0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit tick, input bit r);
        @(negedge clk);
        frame_tick = tick;
        rst = r;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                mx[i] = ARENA_LO;
                mc[i] = 0;
            end else begin
                if (tick) mx[i] = model_pos(mx[i], st[i], opp[i], (i == 0), KEN && (mc[i] != 0 || kq[i]));
                if (KEN && kq[i]) mc[i] = tick ? KF - 1 : KF;
                else if (tick && mc[i] > 0) mc[i]--;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("char_x", i, cx[i], mx[i]);
            chk("knock_busy", i, busy[i], (mc[i] != 0));
            chk("at_left", i, al[i], (mx[i] == ARENA_LO));
            chk("at_right", i, ar[i], (mx[i] == ARENA_HI));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
    endtask

    typedef struct {
        int inst;
        int state;
        int opp;
        int ticks;
        int exp_x;
    } vec_t;

    vec_t tbl [$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 4'd0;
            opp[i] = 10'd500;
            kq[i] = 1'b0;
            mx[i] = ARENA_LO;
            mc[i] = 0;
        end
        opp[1] = 10'd100;

        tbl.push_back('{0, 2, 500, 10, 60});
        tbl.push_back('{0, 2, 488, 160, 360});
        tbl.push_back('{0, 2, 500, 6, 372});
        tbl.push_back('{0, 2, 500, 3, 372});
        tbl.push_back('{0, 1, 169, 166, 40});
        tbl.push_back('{0, 2, 169, 2, 41});
        tbl.push_back('{0, 1, 500, 1, 40});
        tbl.push_back('{0, 1, 500, 3, 40});
        tbl.push_back('{1, 2, 100, 100, 240});
        tbl.push_back('{1, 7, 100, 1, 236});
        tbl.push_back('{1, 7, 100, 2, 228});
        tbl.push_back('{1, 7, 100, 2, 228});

        do_reset();
        chk("reset_x", 0, cx[0], 40);
        chk("reset_y", 0, cy[0], 200);
        chk("reset_busy", 0, busy[0], 0);
        chk("reset_at_left", 0, al[0], 1);

        foreach (tbl[v]) begin
            st[tbl[v].inst] = tbl[v].state[3:0];
            opp[tbl[v].inst] = tbl[v].opp[9:0];
            st[1 - tbl[v].inst] = 4'd0;
            run(tbl[v].ticks);
            chk("table_x", tbl[v].inst, cx[tbl[v].inst], tbl[v].exp_x);
        end
        st[1] = 4'd0;

        do_reset();
        st[0] = 4'd2;
        opp[0] = 10'd500;
        run(130);
        chk("walk_to_300", 0, cx[0], 300);
        kq[0] = 1'b1;
        cycle(1'b0, 1'b0);
        kq[0] = 1'b0;
        chk("busy_rise", 0, busy[0], KEN);
        run(8);
        chk("knock_end_x", 0, cx[0], EXP_K1);
        chk("knock_end_busy", 0, busy[0], 0);
        run(2);
        chk("walk_resume_x", 0, cx[0], EXP_K1B);

        do_reset();
        run(130);
        kq[0] = 1'b1;
        cycle(1'b0, 1'b0);
        kq[0] = 1'b0;
        run(3);
        kq[0] = 1'b1;
        cycle(1'b1, 1'b0);
        kq[0] = 1'b0;
        cycle(1'b0, 1'b0);
        run(7);
        chk("restart_x", 0, cx[0], EXP_K2);
        chk("restart_busy", 0, busy[0], 0);

        kq[0] = 1'b1;
        cycle(1'b0, 1'b0);
        kq[0] = 1'b0;
        run(2);
        kq[0] = 1'b1;
        cycle(1'b1, 1'b1);
        kq[0] = 1'b0;
        chk("rst_knock_x", 0, cx[0], 40);
        chk("rst_knock_busy", 0, busy[0], 0);
        cycle(1'b0, 1'b0);

        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 15) == 0) st[i] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 39) == 0) opp[i] = 10'($urandom_range(0, 700));
                kq[i] = ($urandom_range(0, 40) == 0);
            end
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 799) == 0));
        end
        kq[0] = 1'b0;
        kq[1] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
